// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB has priority, MDU results queue in a small FIFO and drain
// in idle WB cycles, with a starvation stall. Optional same-cycle MDU bypass: RF_WPORT_BYPASS_EN.
module rf_wport_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_en_i,
  input  logic [4:0]               wbaddr_i,
  input  logic [31:0]              wbdata_i,
  input  logic                     mdu_valid_i,
  output logic                     mdu_ready_o,
  input  logic [4:0]               mdu_addr_i,
  input  logic [31:0]              mdu_data_i,
  output logic                     stall_o,
  output logic                     rf_we_o,
  output logic [4:0]               rf_waddr_o,
  output logic [31:0]              rf_wdata_o,
  output logic [31:0]              pend_mask_o,
  output logic [$clog2(DEPTH):0]   fifo_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [SW-1:0] starve_reg;

  logic fifo_empty;
  logic mdu_accept;
  logic mdu_live;
  logic wb_req;
  logic wb_grant;
  logic head_grant;
  logic byp_grant;
  logic enq;
  logic deq;

  logic [4:0]  head_addr;
  logic [31:0] head_data;

  always_comb begin
    fifo_empty  = (count_reg == '0);
    mdu_ready_o = (count_reg < CW'(DEPTH));
    stall_o     = (starve_reg == SW'(STARVE_LIMIT));
    mdu_accept  = mdu_valid_i & mdu_ready_o;
    // Results for x0 are consumed here so they never occupy a slot or reach the port.
    mdu_live    = mdu_accept & (mdu_addr_i != 5'd0);
    wb_req      = wb_en_i & (wbaddr_i != 5'd0);
    wb_grant    = wb_req & ~stall_o;
    head_grant  = ~fifo_empty & (stall_o | ~wb_req);
`ifdef RF_WPORT_BYPASS_EN
    byp_grant   = fifo_empty & ~wb_req & ~stall_o & mdu_live;
`else
    byp_grant   = 1'b0;
`endif
    enq         = mdu_live & ~byp_grant;
    deq         = head_grant;
    head_addr   = addr_mem[rd_ptr_reg];
    head_data   = data_mem[rd_ptr_reg];
  end

  // Result storage: plain RAM, no reset needed since occupancy is tracked by count_reg.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_reg] <= mdu_addr_i;
      data_mem[wr_ptr_reg] <= mdu_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= 5'd0;
      rf_wdata_o <= 32'd0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(enq) - CW'(deq);

      if (fifo_empty || head_grant) starve_reg <= '0;
      else                          starve_reg <= starve_reg + 1'b1;

      rf_we_o <= wb_grant | head_grant | byp_grant;
      if (wb_grant) begin
        rf_waddr_o <= wbaddr_i;
        rf_wdata_o <= wbdata_i;
      end else if (head_grant) begin
        rf_waddr_o <= head_addr;
        rf_wdata_o <= head_data;
      end else if (byp_grant) begin
        rf_waddr_o <= mdu_addr_i;
        rf_wdata_o <= mdu_data_i;
      end
    end
  end

  assign fifo_cnt_o = count_reg;

  // An entry is live when its distance from the read pointer is below the occupancy.
  logic [31:0] entry_hot [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
      logic [PW-1:0] offset;
      logic          live;
      always_comb begin
        offset        = PW'(gi) - rd_ptr_reg;
        live          = ({1'b0, offset} < count_reg);
        entry_hot[gi] = live ? (32'd1 << addr_mem[gi]) : 32'd0;
      end
    end
  endgenerate

  always_comb begin
    pend_mask_o = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_mask_o = pend_mask_o | entry_hot[i];
    end
    pend_mask_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: reset/table vectors, corner-case sequences, and randomized
// traffic checked against a queue-based reference model.
module tb_rf_wport_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef RF_WPORT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_en = 1'b0;
  logic [4:0]  wbaddr = 5'd0;
  logic [31:0] wbdata = 32'd0;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_addr = 5'd0;
  logic [31:0] mdu_data = 32'd0;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
  logic [2:0]  fifo_cnt;

  rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_en_i(wb_en), .wbaddr_i(wbaddr), .wbdata_i(wbdata),
    .mdu_valid_i(mdu_valid), .mdu_ready_o(mdu_ready),
    .mdu_addr_i(mdu_addr), .mdu_data_i(mdu_data),
    .stall_o(stall), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .pend_mask_o(pend_mask), .fifo_cnt_o(fifo_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: queue of pending results plus a wait-cycle counter.
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        obs_stall;

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_we = 1'b0;
    m_addr = 5'd0;
    m_data = 32'd0;
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = 32'd0;
    foreach (mq[i]) m[mq[i].a] = 1'b1;
    return m;
  endfunction

  task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_en = we; wbaddr = wa; wbdata = wd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
  endtask

  // One clock with current inputs; checks combinational outputs, then the registered write.
  task automatic cycle();
    logic acc, wbq, pre_empty, head_g, byp;
    ent_t e;
    #1;
    obs_stall = stall;
    chk("stall", 32'(stall), 32'(m_starve == LIMIT));
    chk("mdu_ready", 32'(mdu_ready), 32'(mq.size() < DEPTH));
    chk("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
    chk("pend_mask", pend_mask, model_mask());
    acc = mdu_valid && (mq.size() < DEPTH);
    wbq = wb_en && (wbaddr != 5'd0);
    pre_empty = (mq.size() == 0);
    head_g = 1'b0;
    byp = 1'b0;
    m_we = 1'b0;
    if (m_starve == LIMIT) head_g = 1'b1;
    else if (wbq) begin m_we = 1'b1; m_addr = wbaddr; m_data = wbdata; end
    else if (!pre_empty) head_g = 1'b1;
    else if (BYP && acc && mdu_addr != 5'd0) begin
      byp = 1'b1; m_we = 1'b1; m_addr = mdu_addr; m_data = mdu_data;
    end
    if (head_g) begin
      e = mq.pop_front();
      m_we = 1'b1; m_addr = e.a; m_data = e.d;
    end
    if (acc && mdu_addr != 5'd0 && !byp) mq.push_back('{mdu_addr, mdu_data});
    m_starve = (pre_empty || head_g) ? 0 : m_starve + 1;
    @(posedge clk); #1;
    chk("rf_we", 32'(rf_we), 32'(m_we));
    if (m_we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(m_addr));
      chk("rf_wdata", rf_wdata, m_data);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic wb_en; logic [4:0] wba; logic [31:0] wbd;
    logic mv; logic [4:0] ma; logic [31:0] md;
    logic ewe; logic [4:0] ea; logic [31:0] ed; logic [2:0] ecnt; logic [31:0] emask;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first_k;
    int lat;
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,    1'b1, 5'd5, 32'hDEADBEEF, 3'd0, 32'h0};
    vecs[1] = '{1'b1, 5'd3, 32'h0000000A, 1'b1, 5'd7, 32'h11,   1'b1, 5'd3, 32'h0000000A, 3'd1, 32'h80};
    vecs[2] = '{1'b1, 5'd3, 32'h0000000B, 1'b0, 5'd0, 32'd0,    1'b1, 5'd3, 32'h0000000B, 3'd1, 32'h80};
    vecs[3] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,    1'b1, 5'd7, 32'h00000011, 3'd0, 32'h0};
    vecs[4] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 32'd0,        3'd0, 32'h0};
    vecs[5] = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 32'd0,        3'd0, 32'h0};
    vecs[6] = '{1'b0, 5'd9, 32'h12345678, 1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 32'd0,        3'd0, 32'h0};
    vecs[7] = '{1'b0, 5'd0, 32'd0,        1'b1, 5'd0, 32'h5,    1'b0, 5'd0, 32'd0,        3'd0, 32'h0};

    // Reset state while held, then ready after release.
    #2;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_mask", pend_mask, 32'd0);
    apply_reset();
    chk("rst_ready", 32'(mdu_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      drv(vecs[i].wb_en, vecs[i].wba, vecs[i].wbd, vecs[i].mv, vecs[i].ma, vecs[i].md);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(vecs[i].ewe));
      if (vecs[i].ewe) begin
        chk($sformatf("vec%0d_addr", i), 32'(rf_waddr), 32'(vecs[i].ea));
        chk($sformatf("vec%0d_data", i), rf_wdata, vecs[i].ed);
      end
      chk($sformatf("vec%0d_cnt", i), 32'(fifo_cnt), 32'(vecs[i].ecnt));
      chk($sformatf("vec%0d_mask", i), pend_mask, vecs[i].emask);
    end

    // MDU to r9 with idle WB and empty FIFO: latency depends on bypass build.
    apply_reset();
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    cycle();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    lat = 0;
    if (rf_we && rf_waddr == 5'd9) lat = 1;
    else begin
      cycle();
      if (rf_we && rf_waddr == 5'd9) lat = 2;
    end
    chk("mdu_latency", 32'(lat), BYP ? 32'd1 : 32'd2);
    cycle();

    // Full FIFO: four results behind a busy WB, fifth held until a slot frees.
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      drv(1'b1, 5'd2, 32'(i), 1'b1, 5'(i + 16), 32'(i * 256));
      cycle();
    end
    chk("full_ready", 32'(mdu_ready), 32'd0);
    chk("full_cnt", 32'(fifo_cnt), 32'd4);
    drv(1'b1, 5'd2, 32'h77, 1'b1, 5'd21, 32'h555);
    cycle();
    chk("full_hold_cnt", 32'(fifo_cnt), 32'd4);
    drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'h555);
    cycle();
    chk("full_deq_cnt", 32'(fifo_cnt), 32'd3);
    cycle();
    chk("full_accept_cnt", 32'(fifo_cnt), 32'd3);
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (4) cycle();

    // Starvation: one queued entry behind continuous WB writes.
    apply_reset();
    drv(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hAAAA);
    cycle();
    drv(1'b1, 5'd1, 32'h2, 1'b0, 5'd0, 32'd0);
    first_k = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (obs_stall && first_k == 0) first_k = k;
    end
    chk("starve_cycle", 32'(first_k), 32'd9);
    chk("starve_after_stall", 32'(stall), 32'd0);
    chk("starve_after_cnt", 32'(fifo_cnt), 32'd0);

    // Reset mid-drain with three queued results.
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 5'd4, 32'(i), 1'b1, 5'(11 + i), 32'(i + 100));
      cycle();
    end
    drv(1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 32'd0);
    chk("middrain_cnt", 32'(fifo_cnt), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("middrain_rf_we", 32'(rf_we), 32'd0);
    chk("middrain_cnt0", 32'(fifo_cnt), 32'd0);
    chk("middrain_mask", pend_mask, 32'd0);
    chk("middrain_stall", 32'(stall), 32'd0);
    model_reset();
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic with alternating busy / idle WB phases.
    for (int i = 0; i < 400; i++) begin
      logic busy;
      busy = ((i / 50) % 2) == 0;
      drv(busy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0),
          5'($urandom_range(0, 31)), $urandom(),
          ($urandom_range(0, 4) < 2),
          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
          $urandom());
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
